sram1024x18_port_ctrl: RTL and testbench
========================================

// Module: sram1024x18_port_ctrl
// PURPOSE
// - Initiator side of one sram1024x18 port: turns a valid/ready request stream into active-low
//   cen/wen/wmsk strobes and returns read data on a valid/ready response stream.
// - Sits between fabric logic and one SRAM port (A or B); one instance per port.
// - Credit-based response FIFO absorbs SRAM read latency and downstream backpressure.
// PARAMETERS
// - ADDR_W     10  SRAM address width
// - DATA_W     18  data / mask width
// - RSP_DEPTH  3   response FIFO entries, legal 2..8; >=3 gives one read per cycle under rsp_ready=1
// PORTS
// - clk         in   1       single clock; also drives the SRAM port clock
// - rst         in   1       synchronous, active-high reset
// - req_valid   in   1       request present
// - req_ready   out  1       request accepted when req_valid & req_ready ("fire")
// - req_we      in   1       1 = write, 0 = read
// - req_addr    in   ADDR_W  word address
// - req_be      in   DATA_W  active-high per-bit write enable (ignored for reads)
// - req_wdata   in   DATA_W  write data
// - rsp_valid   out  1       response present
// - rsp_ready   in   1       response consumed when rsp_valid & rsp_ready ("pop")
// - rsp_rdata   out  DATA_W  read data
// - rsp_wr      out  1       1 = response is a write ack (WRITE_ACK_EN only; else tied 0)
// - sram_cen    out  1       active-low chip enable
// - sram_wen    out  1       active-low write enable
// - sram_addr   out  ADDR_W  SRAM address
// - sram_wmsk   out  DATA_W  active-low bit mask, = ~req_be on write fire
// - sram_wdata  out  DATA_W  SRAM write data
// - sram_rdata  in   DATA_W  SRAM registered read data, valid the cycle after a fire
// BEHAVIOUR
// - SRAM strobes combinational from fire: sram_cen = ~fire; sram_wen = ~(fire & req_we);
//   sram_addr/sram_wdata = req_addr/req_wdata; sram_wmsk = all-ones unless write fire.
// - No fire -> sram_cen=1, sram_wen=1, sram_wmsk all-ones (SRAM idles, rdata holds).
// - inflight (1 reg) and tag (1 reg): set on edge of a response-producing fire, cleared next edge
//   unless another fire; response-producing = read, or any op with WRITE_ACK_EN.
// - Edge after fire (inflight=1): sram_rdata and tag pushed into FIFO; rsp_valid rises that cycle.
//   Read latency: fire at edge N -> rsp_valid=1 in cycle after edge N+1.
// - Credit: req_ready = ~rst & (count + inflight < RSP_DEPTH), from registered state only;
//   pop in the same cycle does not free a credit (no rsp_ready->req_ready path).
//   req_ready independent of req_we; FIFO never overflows by construction.
// - FIFO: push and pop same edge -> count unchanged; pop when empty impossible (rsp_valid=0).
//   Read/write pointers wrap modulo RSP_DEPTH; rsp_rdata/rsp_wr from head entry, stable while
//   rsp_valid & ~rsp_ready.
// - Write without ack: no inflight, no credit consumed; write visible to a read fired next cycle.
// - Read and write to same address on consecutive fires: read returns new data.
// - Reset (any cycle, incl. mid-transfer): count, pointers, inflight <= 0; rsp_valid=0,
//   rsp_wr=0, rsp_rdata=0; req_ready=0 while rst=1 so sram_cen=1; SRAM data from a fire
//   in the reset cycle's predecessor is discarded.
// CONFIGURATION
// - WRITE_ACK_EN defined: every write fire consumes a credit and returns a response with
//   rsp_wr=1, rsp_rdata = pre-write word contents (SRAM read-before-write); order preserved.
// - WRITE_ACK_EN undefined: writes fire-and-forget, rsp_wr tied 0, FIFO has no tag bit.
// TESTING
// - Write addr 0x155 data 0x2A5A5 be all-ones, then read 0x155 -> rsp_rdata=0x2A5A5 one cycle after read fire.
// - Preload 0x3FFFF at 0x010; write 0x00000 with be=0x000FF; read -> 0x3FF00.
// - Hold rsp_ready=0, stream reads -> exactly RSP_DEPTH fires, then req_ready=0; release -> data in order.
// - rsp_ready=1, back-to-back reads of 0..15, RSP_DEPTH=3 -> 16 fires in 16 cycles, data in order.
// - Assert rst for 1 cycle with 2 responses queued and 1 in flight -> rsp_valid=0 next cycle, no stale data.
// - WRITE_ACK_EN: addr 0x3FF holds 0x00001, write 0x12345 -> rsp_wr=1, rsp_rdata=0x00001.

Source files
------------

// File: rtl/sram1024x18_port_ctrl.sv
// ---------------------------------------------------------------------------
// sram1024x18_port_ctrl
// Initiator side of one sram1024x18 port. Turns a valid/ready request stream
// into active-low SRAM strobes and returns read data on a valid/ready
// response stream. A credit-checked response FIFO absorbs the one-cycle SRAM
// read latency and downstream backpressure. One instance per SRAM port.
//
// Optional feature macro: WRITE_ACK_EN
//   defined   : every write returns a response (o_rsp_wr=1, o_rsp_rdata =
//               word contents before the write), ordered with reads.
//   undefined : writes are fire-and-forget, o_rsp_wr tied 0.
//
// Handshake: a beat transfers on an edge where valid & ready are both 1.
// Requests fire on i_req_valid & o_req_ready; responses pop on
// o_rsp_valid & i_rsp_ready. o_req_ready never depends on i_req_valid or
// i_rsp_ready, and response outputs hold while o_rsp_valid & ~i_rsp_ready.
//
// Ports
//   i_clk, i_rst            clock (also the SRAM port clock), sync active-high reset
//   i_req_valid/o_req_ready request handshake
//   i_req_we                1 = write, 0 = read
//   i_req_addr              word address
//   i_req_be                active-high per-bit write enable
//   i_req_wdata             write data
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_rdata             read data (0 when no response present)
//   o_rsp_wr                response is a write ack
//   o_sram_cen/o_sram_wen   active-low chip / write enable
//   o_sram_addr             SRAM address
//   o_sram_wmsk             active-low bit mask
//   o_sram_wdata            SRAM write data
//   i_sram_rdata            SRAM registered read data
// ---------------------------------------------------------------------------
module sram1024x18_port_ctrl #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 18,
   parameter int RSP_DEPTH = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_be,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_rsp_wr,
   output logic              o_sram_cen,
   output logic              o_sram_wen,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [DATA_W-1:0] o_sram_wmsk,
   output logic [DATA_W-1:0] o_sram_wdata,
   input  logic [DATA_W-1:0] i_sram_rdata
);

   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam logic [CNT_W:0]   L_DEPTH = (CNT_W + 1)'(RSP_DEPTH);
   localparam logic [PTR_W-1:0] L_LAST  = PTR_W'(RSP_DEPTH - 1);

   logic              r_inflight;
   logic [CNT_W-1:0]  r_count;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [DATA_W-1:0] r_mem [RSP_DEPTH];

   logic              w_fire;
   logic              w_wr_fire;
   logic              w_rsp_fire;
   logic              w_push;
   logic              w_pop;
   logic [CNT_W:0]    w_used;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == L_LAST) ? '0 : p + 1'b1;
   endfunction

   // Credit: queued entries plus the one possibly in flight must leave room.
   // Only registered state is used, so a same-cycle pop never frees a credit.
   assign w_used      = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
   assign o_req_ready = ~i_rst & (w_used < L_DEPTH);

   assign w_fire    = i_req_valid & o_req_ready;
   assign w_wr_fire = w_fire & i_req_we;

`ifdef WRITE_ACK_EN
   assign w_rsp_fire = w_fire;
`else
   assign w_rsp_fire = w_fire & ~i_req_we;
`endif

   assign o_sram_cen   = ~w_fire;
   assign o_sram_wen   = ~w_wr_fire;
   assign o_sram_addr  = i_req_addr;
   assign o_sram_wdata = i_req_wdata;
   assign o_sram_wmsk  = w_wr_fire ? ~i_req_be : {DATA_W{1'b1}};

   // The SRAM data for a fire is valid exactly while r_inflight is set.
   assign w_push      = r_inflight;
   assign o_rsp_valid = (r_count != '0);
   assign w_pop       = o_rsp_valid & i_rsp_ready;
   assign o_rsp_rdata = o_rsp_valid ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_inflight <= 1'b0;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         r_inflight <= w_rsp_fire;
         if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset: the output is masked while empty.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_sram_rdata;
   end

`ifdef WRITE_ACK_EN
   logic r_tag;
   logic r_tag_mem [RSP_DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_rst) r_tag <= 1'b0;
      else       r_tag <= i_req_we;
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_tag_mem[r_wr_ptr] <= r_tag;
   end

   assign o_rsp_wr = o_rsp_valid & r_tag_mem[r_rd_ptr];
`else
   assign o_rsp_wr = 1'b0;
`endif

endmodule

// File: tb/tb_sram1024x18_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram1024x18_port_ctrl
// Directed bench for sram1024x18_port_ctrl with a behavioural SRAM
// (registered read, read-before-write, active-low bit mask). Expected
// responses go through a scoreboard queue; a table of request vectors drives
// the main function and hand sequences cover backpressure, throughput and
// mid-transfer reset.
// ---------------------------------------------------------------------------
module tb_sram1024x18_port_ctrl;

   localparam int AW    = 10;
   localparam int DW    = 18;
   localparam int DEPTH = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          mem_clr;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_be;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_wr;
   logic          sram_cen;
   logic          sram_wen;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wmsk;
   logic [DW-1:0] sram_wdata;
   logic [DW-1:0] sram_rdata;

   sram1024x18_port_ctrl #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .RSP_DEPTH (DEPTH)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_we     (req_we),
      .i_req_addr   (req_addr),
      .i_req_be     (req_be),
      .i_req_wdata  (req_wdata),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_rdata  (rsp_rdata),
      .o_rsp_wr     (rsp_wr),
      .o_sram_cen   (sram_cen),
      .o_sram_wen   (sram_wen),
      .o_sram_addr  (sram_addr),
      .o_sram_wmsk  (sram_wmsk),
      .o_sram_wdata (sram_wdata),
      .i_sram_rdata (sram_rdata)
   );

   // ---------------- SRAM model ----------------
   logic [DW-1:0] sram_mem [1024];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) sram_mem[i] <= '0;
         sram_rdata <= '0;
      end else if (!sram_cen) begin
         sram_rdata <= sram_mem[sram_addr];
         if (!sram_wen)
            sram_mem[sram_addr] <= (sram_mem[sram_addr] & sram_wmsk) | (sram_wdata & ~sram_wmsk);
      end
   end

   // ---------------- scoreboard ----------------
   logic [DW:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        last_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: sample at the falling edge, return just after the rising edge.
   task automatic tick();
      logic [DW:0] e;
      @(negedge clk);
      last_ready = req_ready;
      if (rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: got 0x%0h expected no response", {rsp_wr, rsp_rdata});
         end else begin
            e = exp_q.pop_front();
            check("rsp_data", {13'b0, rsp_wr, rsp_rdata}, {13'b0, e});
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver ----------------
   task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] be,
                       input logic [DW-1:0] wdata, output int waits);
      logic [DW-1:0] msk;
      req_we    = we;
      req_addr  = addr;
      req_be    = be;
      req_wdata = wdata;
      req_valid = 1'b1;
      #1;
      if (req_ready) begin
         msk = we ? ~be : {DW{1'b1}};
         check("strobe_cen",  {31'b0, sram_cen}, 32'd0);
         check("strobe_wen",  {31'b0, sram_wen}, {31'b0, ~we});
         check("strobe_wmsk", {14'b0, sram_wmsk}, {14'b0, msk});
         check("strobe_addr", {22'b0, sram_addr}, {22'b0, addr});
      end
      waits = 0;
      tick();
      while (!last_ready && waits < 200) begin
         waits++;
         tick();
      end
      if (!last_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got req_ready=0 for %0d cycles expected a fire", waits);
      end
      req_valid = 1'b0;
   endtask

   task automatic push_ack(input logic [DW-1:0] old);
`ifdef WRITE_ACK_EN
      exp_q.push_back({1'b1, old});
`else
      if (old === 'x) exp_q.push_back('0);
`endif
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      check("drain_empty", exp_q.size(), 32'd0);
      repeat (2) tick();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] be;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;   // read data, or pre-write contents for a write
   } vec_t;

   vec_t vecs[13];

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test expected finish");
      $fatal(1);
   end

   initial begin
      int w;
      int fires;
      int stalls;

      vecs[0]  = '{1'b1, 10'h155, 18'h3FFFF, 18'h2A5A5, 18'h2A5A5};
      vecs[1]  = '{1'b0, 10'h155, 18'h3FFFF, 18'h00000, 18'h2A5A5};
      vecs[2]  = '{1'b1, 10'h010, 18'h3FFFF, 18'h3FFFF, 18'h00000};
      vecs[3]  = '{1'b1, 10'h010, 18'h000FF, 18'h00000, 18'h3FFFF};
      vecs[4]  = '{1'b0, 10'h010, 18'h3FFFF, 18'h00000, 18'h3FF00};
      vecs[5]  = '{1'b1, 10'h000, 18'h3FFFF, 18'h12345, 18'h00000};
      vecs[6]  = '{1'b0, 10'h000, 18'h3FFFF, 18'h00000, 18'h12345};
      vecs[7]  = '{1'b1, 10'h3FF, 18'h3FFFF, 18'h00001, 18'h00000};
      vecs[8]  = '{1'b0, 10'h3FF, 18'h3FFFF, 18'h00000, 18'h00001};
      vecs[9]  = '{1'b1, 10'h155, 18'h0F0F0, 18'h3C3C3, 18'h2A5A5};
      vecs[10] = '{1'b0, 10'h155, 18'h3FFFF, 18'h00000, 18'h2C5C5};
      vecs[11] = '{1'b1, 10'h3FF, 18'h3FFFF, 18'h12345, 18'h00001};
      vecs[12] = '{1'b0, 10'h3FF, 18'h3FFFF, 18'h00000, 18'h12345};

      // ---- reset ----
      rst       = 1'b1;
      mem_clr   = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = '0;
      req_be    = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", {31'b0, req_ready}, 32'd0);
      check("rst_cen",       {31'b0, sram_cen},  32'd1);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", {14'b0, rsp_rdata}, 32'd0);
      check("rst_rsp_wr",    {31'b0, rsp_wr},    32'd0);
      rst       = 1'b0;
      mem_clr   = 1'b0;
      req_valid = 1'b0;
      #1;
      check("idle_req_ready", {31'b0, req_ready}, 32'd1);
      check("idle_cen",       {31'b0, sram_cen},  32'd1);
      check("idle_wen",       {31'b0, sram_wen},  32'd1);
      check("idle_wmsk",      {14'b0, sram_wmsk}, 32'h3FFFF);
      tick();

      // ---- read latency after a write ----
      push_ack(18'h00000);
      send(1'b1, 10'h155, 18'h3FFFF, 18'h2A5A5, w);
      drain();
      send(1'b0, 10'h155, 18'h3FFFF, 18'h00000, w);
      check("lat_valid_n0", {31'b0, rsp_valid}, 32'd0);
      tick();
      check("lat_valid_n1", {31'b0, rsp_valid}, 32'd1);
      check("lat_rdata",    {14'b0, rsp_rdata}, 32'h2A5A5);
      exp_q.push_back({1'b0, 18'h2A5A5});
      drain();

      // ---- table vectors, back-to-back ----
      for (int i = 0; i < 13; i++) begin
         if (vecs[i].we) push_ack(vecs[i].exp);
         else            exp_q.push_back({1'b0, vecs[i].exp});
         send(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, w);
      end
      drain();

      // ---- preload 0x020..0x02F ----
      for (int k = 0; k < 16; k++) begin
         push_ack(18'h00000);
         send(1'b1, AW'(10'h020 + k), 18'h3FFFF, 18'h15A00 | DW'(k), w);
      end
      drain();

      // ---- backpressure: only DEPTH reads may be accepted ----
      rsp_ready = 1'b0;
      fires     = 0;
      req_we    = 1'b0;
      req_be    = 18'h3FFFF;
      req_addr  = 10'h020;
      req_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (last_ready) begin
            exp_q.push_back({1'b0, 18'h15A00 | DW'(fires)});
            fires++;
            req_addr = AW'(10'h020 + fires);
         end
      end
      req_valid = 1'b0;
      check("bp_fires",     fires,              DEPTH);
      check("bp_ready_low", {31'b0, req_ready}, 32'd0);
      check("bp_valid",     {31'b0, rsp_valid}, 32'd1);
      check("bp_head",      {14'b0, rsp_rdata}, 32'h15A00);
      tick();
      check("bp_stable",    {14'b0, rsp_rdata}, 32'h15A00);
      rsp_ready = 1'b1;
      drain();

      // ---- throughput: 16 reads in 16 cycles ----
      stalls = 0;
      for (int k = 0; k < 16; k++) begin
         exp_q.push_back({1'b0, 18'h15A00 | DW'(k)});
         send(1'b0, AW'(10'h020 + k), 18'h3FFFF, 18'h00000, w);
         stalls += w;
      end
      check("tp_stalls", stalls, 32'd0);
      drain();

      // ---- reset with 2 queued and 1 in flight ----
      rsp_ready = 1'b0;
      send(1'b0, 10'h021, 18'h3FFFF, 18'h00000, w);
      send(1'b0, 10'h022, 18'h3FFFF, 18'h00000, w);
      send(1'b0, 10'h023, 18'h3FFFF, 18'h00000, w);
      check("mid_ready_full", {31'b0, req_ready}, 32'd0);
      rst       = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 10'h024;
      #1;
      check("mid_rst_ready", {31'b0, req_ready}, 32'd0);
      check("mid_rst_cen",   {31'b0, sram_cen},  32'd1);
      tick();
      rst       = 1'b0;
      req_valid = 1'b0;
      #1;
      check("post_rst_valid", {31'b0, rsp_valid}, 32'd0);
      check("post_rst_rdata", {14'b0, rsp_rdata}, 32'd0);
      check("post_rst_wr",    {31'b0, rsp_wr},    32'd0);
      check("post_rst_ready", {31'b0, req_ready}, 32'd1);
      rsp_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("post_rst_no_stale", {31'b0, rsp_valid}, 32'd0);
      end
      exp_q.push_back({1'b0, 18'h15A05});
      send(1'b0, 10'h025, 18'h3FFFF, 18'h00000, w);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
